// File: rtl/ble6_cfg_lut_pkg.sv
// Shared definitions for the serially configured 6-input LUT basic logic element:
// configuration FSM states, default LUT size and configuration frame length.
package ble6_cfg_lut_pkg;

   localparam int LUT_K_DEFAULT = 6;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      ARMED = 2'd2
   } cfg_state_e;

   // Frame = full truth table plus the BLE output-select bit on top.
   function automatic int cfg_bits_f(input int lut_k);
      return (1 << lut_k) + 1;
   endfunction

endpackage

// File: rtl/ble6_cfg_shift_reg.sv
// Configuration SRAM as a serial shift chain; the top bit leaves on cfg_tail
// so several BLEs can be daisy-chained on one configuration line.
module ble6_cfg_shift_reg
   import ble6_cfg_lut_pkg::*;
#(
   parameter int CFG_BITS = cfg_bits_f(LUT_K_DEFAULT)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                shift_en,
   input  logic                din,
   output logic [CFG_BITS-1:0] sram,
   output logic                tail
);

   logic [CFG_BITS-1:0] sram_q;
   logic [CFG_BITS-1:0] sram_d;

   always_comb begin
      sram_d = sram_q;
      if (shift_en) begin
         sram_d = {sram_q[CFG_BITS-2:0], din};
      end
   end

   // NOTE: the configuration store is reset like any other flop, so a reset
   // part-way through a load can never leave a half-written table active.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sram_q <= '0;
      end else begin
         // NOTE: non-blocking so every stage samples its neighbour's old value.
         sram_q <= sram_d;
      end
   end

   assign sram = sram_q;
   assign tail = sram_q[CFG_BITS-1];

endmodule

// File: rtl/ble6_cfg_lut.sv
// Serially configured K-input LUT for one BLE: frame-tracking FSM, saturating
// bit counter and the truth-table read mux around the configuration shift chain.
module ble6_cfg_lut
   import ble6_cfg_lut_pkg::*;
#(
   parameter int LUT_K    = LUT_K_DEFAULT,
   parameter int CFG_BITS = cfg_bits_f(LUT_K)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cfg_en,
   input  logic             cfg_head,
   output logic             cfg_tail,
   input  logic [LUT_K-1:0] lut_in,
   output logic             lut_out,
   output logic             ble_out_sel,
   output logic             cfg_done,
   output logic             cfg_err
);

   localparam int CNT_W    = $clog2(CFG_BITS) + 1;
   localparam int TABLE_SZ = 1 << LUT_K;

   logic [CFG_BITS-1:0] sram;
   logic [TABLE_SZ-1:0] lut_table;

   cfg_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   ble6_cfg_shift_reg #(
      .CFG_BITS (CFG_BITS)
   ) u_shift_reg (
      .clk      (clk),
      .reset    (reset),
      .shift_en (cfg_en),
      .din      (cfg_head),
      .sram     (sram),
      .tail     (cfg_tail)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = done_q;
      err_d   = err_q;
      if (cfg_en) begin
         if (state_q != LOAD) begin
            // The entering cycle already shifts, so the count starts at one.
            state_d = LOAD;
            cnt_d   = CNT_W'(1);
            done_d  = 1'b0;
            err_d   = 1'b0;
         end else if (cnt_q < CNT_W'(CFG_BITS)) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else if (state_q == LOAD) begin
         if (cnt_q == CNT_W'(CFG_BITS)) begin
            state_d = ARMED;
            done_d  = 1'b1;
         end else begin
            state_d = IDLE;
            err_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // Outputs stay quiet until a complete frame is armed.
   assign lut_table   = sram[TABLE_SZ-1:0];
   assign lut_out     = (state_q == ARMED) ? lut_table[lut_in] : 1'b0;
   assign ble_out_sel = (state_q == ARMED) ? sram[CFG_BITS-1] : 1'b0;
   assign cfg_done    = done_q;
   assign cfg_err     = err_q;

endmodule

// File: tb/tb_ble6_cfg_lut.sv
// Randomized self-checking bench for ble6_cfg_lut against a bit-history model
// of the configuration chain.
`timescale 1ns/1ps
module tb_ble6_cfg_lut;

   localparam int K  = 6;
   localparam int CB = (1 << K) + 1;

   logic         clk = 1'b0;
   logic         reset;
   logic         cfg_en;
   logic         cfg_head;
   logic         cfg_tail;
   logic [K-1:0] lut_in;
   logic         lut_out;
   logic         ble_out_sel;
   logic         cfg_done;
   logic         cfg_err;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: every bit shifted since reset (newest at the back),
   // plus frame bookkeeping expressed as "bits in current burst".
   bit hist[$];
   bit in_load;
   int load_len;
   bit armed;
   bit err;

   ble6_cfg_lut dut (
      .clk         (clk),
      .reset       (reset),
      .cfg_en      (cfg_en),
      .cfg_head    (cfg_head),
      .cfg_tail    (cfg_tail),
      .lut_in      (lut_in),
      .lut_out     (lut_out),
      .ble_out_sel (ble_out_sel),
      .cfg_done    (cfg_done),
      .cfg_err     (cfg_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Bit j of the configuration store = the bit shifted j shifts ago.
   function automatic bit sram_bit(input int j);
      int n = hist.size();
      if (j < n) return hist[n-1-j];
      return 1'b0;
   endfunction

   function automatic bit exp_lut(input int idx);
      return armed ? sram_bit(idx) : 1'b0;
   endfunction

   task automatic model_reset();
      hist.delete();
      in_load  = 1'b0;
      load_len = 0;
      armed    = 1'b0;
      err      = 1'b0;
   endtask

   task automatic check_outputs();
      check("done", cfg_done, armed);
      check("err", cfg_err, err);
      check("sel", ble_out_sel, armed ? sram_bit(CB-1) : 1'b0);
      check("lut", lut_out, exp_lut(lut_in));
   endtask

   // One clock of activity; called away from the rising edge.
   task automatic step(input bit en, input bit b);
      cfg_en   = en;
      cfg_head = b;
      #1;
      check("tail", cfg_tail, sram_bit(CB-1));
      @(posedge clk);
      #1;
      if (en) begin
         if (!in_load) begin
            in_load  = 1'b1;
            load_len = 0;
            armed    = 1'b0;
            err      = 1'b0;
         end
         hist.push_back(b);
         if (hist.size() > CB) void'(hist.pop_front());
         load_len++;
      end else if (in_load) begin
         in_load = 1'b0;
         if (load_len >= CB) armed = 1'b1;
         else err = 1'b1;
      end
      lut_in = K'($urandom);
      #1;
      check_outputs();
   endtask

   task automatic load_frame(input bit sel, input logic [63:0] tbl);
      step(1'b1, sel);
      for (int i = 63; i >= 0; i--) step(1'b1, tbl[i]);
      step(1'b0, 1'b0);
   endtask

   // Only used while cfg_en is low, so clock edges in between change nothing.
   task automatic sweep(input string tag);
      for (int i = 0; i < 64; i++) begin
         lut_in = K'(i);
         #1;
         check(tag, lut_out, exp_lut(i));
      end
   endtask

   task automatic zero_outputs(input string tag);
      check({tag, "_lut"}, lut_out, 1'b0);
      check({tag, "_sel"}, ble_out_sel, 1'b0);
      check({tag, "_tail"}, cfg_tail, 1'b0);
      check({tag, "_done"}, cfg_done, 1'b0);
      check({tag, "_err"}, cfg_err, 1'b0);
   endtask

   initial begin
      logic [63:0] tbl;
      bit          frame_a[CB];
      bit          sel;
      int          len;

      reset    = 1'b1;
      cfg_en   = 1'b0;
      cfg_head = 1'b0;
      lut_in   = '0;
      model_reset();
      #1;
      zero_outputs("reset");
      @(negedge clk);
      reset = 1'b0;

      // Single-minterm table: only index 63 is set, output registered.
      load_frame(1'b1, 64'h8000_0000_0000_0000);
      check("one_hot_done", cfg_done, 1'b1);
      check("one_hot_sel", ble_out_sel, 1'b1);
      for (int i = 0; i < 64; i++) begin
         lut_in = K'(i);
         #1;
         check("one_hot_lut", lut_out, (i == 63) ? 1'b1 : 1'b0);
      end

      // Short frame of 40 bits.
      for (int i = 0; i < 40; i++) step(1'b1, 1'($urandom));
      step(1'b0, 1'b0);
      check("short_err", cfg_err, 1'b1);
      check("short_done", cfg_done, 1'b0);
      sweep("short_lut");
      step(1'b1, 1'($urandom));
      check("short_err_clr", cfg_err, 1'b0);
      for (int i = 0; i < CB - 1; i++) step(1'b1, 1'($urandom));
      step(1'b0, 1'b0);
      check("reload_done", cfg_done, 1'b1);

      // Two back-to-back frames: tail replays frame A from shift 66 on.
      for (int i = 0; i < CB; i++) frame_a[i] = 1'($urandom);
      for (int k = 1; k <= 2 * CB; k++) begin
         if (k > CB) begin
            #1;
            check("tail_replay", cfg_tail, frame_a[k-CB-1]);
         end
         step(1'b1, (k <= CB) ? frame_a[k-1] : 1'($urandom));
      end
      step(1'b0, 1'b0);
      check("chain_done", cfg_done, 1'b1);
      sweep("chain_lut");

      // Asynchronous reset 30 shifts into a load.
      for (int i = 0; i < 30; i++) step(1'b1, 1'b1);
      reset = 1'b1;
      #1;
      model_reset();
      zero_outputs("async_rst");
      cfg_en = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      step(1'b0, 1'b0);
      check("no_arm_after_rst", cfg_done, 1'b0);
      load_frame(1'($urandom), {$urandom, $urandom});
      check("rst_reload_done", cfg_done, 1'b1);
      sweep("rst_reload_lut");

      // 6-input XOR parity table.
      sel = 1'($urandom);
      load_frame(sel, 64'h6996_9669_9669_6996);
      for (int i = 0; i < 64; i++) begin
         lut_in = K'(i);
         #1;
         check("parity_lut", lut_out, ^i[5:0]);
         check("parity_sel", ble_out_sel, sel);
      end
      repeat (20) step(1'b0, 1'b0);
      check("parity_hold_sel", ble_out_sel, sel);
      sweep("parity_hold_lut");

      // Re-entering LOAD from ARMED drops cfg_done and gates lut_out.
      tbl = {$urandom, $urandom};
      step(1'b1, 1'b0);
      check("rearm_done", cfg_done, 1'b0);
      check("rearm_lut", lut_out, 1'b0);
      for (int i = 63; i >= 0; i--) begin
         step(1'b1, tbl[i]);
         check("rearm_lut_gated", lut_out, 1'b0);
      end
      step(1'b0, 1'b0);
      check("rearm_done_final", cfg_done, 1'b1);
      for (int i = 0; i < 64; i++) begin
         lut_in = K'(i);
         #1;
         check("rearm_table", lut_out, tbl[i]);
      end

      // Random bursts of random length.
      for (int r = 0; r < 8; r++) begin
         len = $urandom_range(1, 2 * CB + 5);
         for (int i = 0; i < len; i++) step(1'b1, 1'($urandom));
         step(1'b0, 1'b0);
         check("rand_done", cfg_done, (len >= CB) ? 1'b1 : 1'b0);
         check("rand_err", cfg_err, (len < CB) ? 1'b1 : 1'b0);
         sweep("rand_lut");
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
